// File: rtl/bpsk_demod.sv
// Coherent BPSK demodulator: correlates 8-bit carrier samples against a phase-aligned
// square reference, integrates over one bit period and slices the sign into a bit.
module bpsk_demod #(
  parameter int CYCLES_PER_BIT = 4,
  parameter int ACC_W          = 24
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             enable,
  input  logic             sync,
  input  logic             sample_valid,
  input  logic [7:0]       sample,
  output logic             bit_out,
  output logic             bit_valid,
  output logic [ACC_W-1:0] corr_out,
  output logic [15:0]      bit_count,
  output logic             locked
);

  typedef enum logic {IDLE = 1'b0, RUN = 1'b1} state_t;

  localparam logic [7:0] LAST_CYC = 8'(CYCLES_PER_BIT - 1);

  function automatic logic signed [8:0] center(input logic [7:0] s);
    return $signed({1'b0, s}) - 9'sd128;
  endfunction

  // Reference is +1 over the high half of the carrier (phase 32..95), -1 elsewhere.
  function automatic logic signed [ACC_W-1:0] correlate(input logic [6:0] ph,
                                                        input logic signed [8:0] c);
    logic signed [ACC_W-1:0] ext;
    ext = ACC_W'(c);
    return (ph >= 7'd32 && ph <= 7'd95) ? ext : -ext;
  endfunction

  state_t                  state_q, state_d;
  logic [6:0]              phase_p0, phase_d, base_phase;
  logic [7:0]              cyc_p0, cyc_d, base_cyc;
  logic signed [ACC_W-1:0] acc_p0, acc_d, base_acc, total_d;
  logic                    active, dec_d;

  always_comb begin
    state_d    = state_q;
    phase_d    = phase_p0;
    cyc_d      = cyc_p0;
    acc_d      = acc_p0;
    base_phase = phase_p0;
    base_cyc   = cyc_p0;
    base_acc   = acc_p0;
    total_d    = acc_p0;
    dec_d      = 1'b0;
    active     = 1'b0;
    if (!enable) begin
      state_d = IDLE;
      phase_d = '0;
      cyc_d   = '0;
      acc_d   = '0;
    end else begin
      // A sync restarts the frame; a sample in the same cycle is phase 0 of it.
      if (sync) begin
        state_d    = RUN;
        base_phase = '0;
        base_cyc   = '0;
        base_acc   = '0;
        phase_d    = '0;
        cyc_d      = '0;
        acc_d      = '0;
        active     = 1'b1;
      end else begin
        active = (state_q == RUN);
      end
      if (active && sample_valid) begin
        total_d = base_acc + correlate(base_phase, center(sample));
        phase_d = base_phase + 7'd1;
        acc_d   = total_d;
        if (base_phase == 7'd127) begin
          if (base_cyc == LAST_CYC) begin
            dec_d = 1'b1;
            cyc_d = '0;
            acc_d = '0;
          end else begin
            cyc_d = base_cyc + 8'd1;
          end
        end
      end
    end
  end

  // Stage p0: state, phase/period counters and running correlation
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= IDLE;
      phase_p0 <= '0;
      cyc_p0   <= '0;
      acc_p0   <= '0;
    end else begin
      state_q  <= state_d;
      phase_p0 <= phase_d;
      cyc_p0   <= cyc_d;
      acc_p0   <= acc_d;
    end
  end

  // Stage p1: decision outputs, one clock after the final sample of a bit
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      bit_valid <= 1'b0;
      bit_out   <= 1'b0;
      corr_out  <= '0;
      bit_count <= '0;
    end else begin
      bit_valid <= dec_d;
      if (dec_d) begin
        bit_out   <= (total_d > 0);
        corr_out  <= total_d;
        bit_count <= bit_count + 16'd1;
      end
    end
  end

  assign locked = (state_q == RUN);

endmodule

// File: tb/tb_bpsk_demod.sv
// Bench for bpsk_demod: two instances (1 and 4 carrier periods per bit) driven by the
// same stimulus, each compared every cycle against a frame-buffer correlation model.
module tb_bpsk_demod;

  logic        clk = 1'b0;
  logic        reset_n, enable, sync, sample_valid;
  logic [7:0]  sample;
  logic        bo1, bv1, lk1, bo4, bv4, lk4;
  logic [23:0] corr1, corr4;
  logic [15:0] cnt1, cnt4;

  always #5 clk = ~clk;

  bpsk_demod #(.CYCLES_PER_BIT(1), .ACC_W(24)) dut1 (
    .clk(clk), .reset_n(reset_n), .enable(enable), .sync(sync),
    .sample_valid(sample_valid), .sample(sample), .bit_out(bo1), .bit_valid(bv1),
    .corr_out(corr1), .bit_count(cnt1), .locked(lk1));

  bpsk_demod #(.CYCLES_PER_BIT(4), .ACC_W(24)) dut4 (
    .clk(clk), .reset_n(reset_n), .enable(enable), .sync(sync),
    .sample_valid(sample_valid), .sample(sample), .bit_out(bo4), .bit_valid(bv4),
    .corr_out(corr4), .bit_count(cnt4), .locked(lk4));

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model: buffer accepted samples of a frame, correlate once it is full.
  int     cpbv[2] = '{1, 4};
  bit     m_run[2];
  int     mq[2][$];
  int     e_bv[2], e_bit[2], e_cnt[2];
  longint e_corr[2];

  longint s4_corr[$];
  int     s4_bit[$];
  int     s4_at[$];
  int     acc_cnt;

  task automatic chk(input string tag, input longint got, input longint exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int n = 0; n < 2; n++) begin
      m_run[n] = 1'b0;
      mq[n].delete();
      e_bv[n] = 0; e_bit[n] = 0; e_cnt[n] = 0; e_corr[n] = 0;
    end
  endtask

  task automatic model_edge();
    for (int n = 0; n < 2; n++) begin
      e_bv[n] = 0;
      if (!enable) begin
        m_run[n] = 1'b0;
        mq[n].delete();
      end else begin
        if (sync) begin
          m_run[n] = 1'b1;
          mq[n].delete();
        end
        if (m_run[n] && sample_valid) begin
          mq[n].push_back(int'(sample));
          if (mq[n].size() == 128 * cpbv[n]) begin
            longint s = 0;
            for (int i = 0; i < mq[n].size(); i++) begin
              int ph = i % 128;
              int c  = mq[n][i] - 128;
              s += (ph >= 32 && ph < 96) ? c : -c;
            end
            e_bv[n]   = 1;
            e_bit[n]  = (s > 0) ? 1 : 0;
            e_corr[n] = s;
            e_cnt[n]  = (e_cnt[n] + 1) % 65536;
            mq[n].delete();
          end
        end
      end
    end
  endtask

  task automatic compare_all();
    chk("bv1",   longint'(bv1), e_bv[0]);
    chk("bit1",  longint'(bo1), e_bit[0]);
    chk("corr1", longint'($signed(corr1)), e_corr[0]);
    chk("cnt1",  longint'(cnt1), e_cnt[0]);
    chk("lock1", longint'(lk1), longint'(m_run[0]));
    chk("bv4",   longint'(bv4), e_bv[1]);
    chk("bit4",  longint'(bo4), e_bit[1]);
    chk("corr4", longint'($signed(corr4)), e_corr[1]);
    chk("cnt4",  longint'(cnt4), e_cnt[1]);
    chk("lock4", longint'(lk4), longint'(m_run[1]));
  endtask

  task automatic step();
    if (sample_valid && enable) acc_cnt++;
    @(posedge clk);
    if (reset_n) model_edge();
    #1;
    if (bv4) begin
      s4_corr.push_back(longint'($signed(corr4)));
      s4_bit.push_back(int'(bo4));
      s4_at.push_back(acc_cnt);
    end
    compare_all();
  endtask

  function automatic logic [7:0] gen(input int mode, input int i, input int bitpat);
    int ph = i % 128;
    int c;
    real r;
    case (mode)
      0: return (ph >= 32 && ph < 96) ? 8'd255 : 8'd0;
      1: return (ph >= 32 && ph < 96) ? 8'd0 : 8'd255;
      2: return 8'd255;
      default: begin
        r = 127.5 - 127.5 * $cos(2.0 * 3.141592653589793 * ph / 128.0);
        c = $rtoi(r + 0.5);
        if (((bitpat >> (i / 512)) & 1) == 0) c = 255 - c;
        return 8'(c);
      end
    endcase
  endfunction

  task automatic feed(input int n, input int mode, input int gap_pct,
                      input bit with_sync, input int bitpat);
    for (int i = 0; i < n; i++) begin
      while (int'($urandom_range(99)) < gap_pct) begin
        sample_valid = 1'b0;
        sync         = 1'b0;
        sample       = 8'($urandom_range(255));
        step();
      end
      sample_valid = 1'b1;
      sync         = with_sync && (i == 0);
      sample       = gen(mode, i, bitpat);
      step();
    end
    sample_valid = 1'b0;
    sync         = 1'b0;
  endtask

  task automatic clear_mon();
    s4_corr.delete();
    s4_bit.delete();
    s4_at.delete();
    acc_cnt = 0;
  endtask

  int saved_cnt;

  initial begin
    reset_n = 1'b0; enable = 1'b0; sync = 1'b0; sample_valid = 1'b0; sample = 8'd0;
    model_reset();
    clear_mon();
    #2;
    step();
    step();
    chk("rst_bv", longint'(bv1), 0);
    chk("rst_corr", longint'($signed(corr4)), 0);
    chk("rst_lock", longint'(lk4), 0);

    @(negedge clk);
    reset_n = 1'b1;
    enable  = 1'b1;
    step();

    feed(128, 0, 0, 1'b1, 0);
    chk("hi_bv", longint'(bv1), 1);
    chk("hi_bit", longint'(bo1), 1);
    chk("hi_corr", longint'($signed(corr1)), 16320);
    chk("hi_cnt", longint'(cnt1), 1);
    step();
    chk("hi_strobe_len", longint'(bv1), 0);

    feed(128, 1, 0, 1'b1, 0);
    chk("lo_bv", longint'(bv1), 1);
    chk("lo_bit", longint'(bo1), 0);
    chk("lo_corr", longint'($signed(corr1)), -16320);

    feed(128, 2, 0, 1'b1, 0);
    chk("tie_bit", longint'(bo1), 0);
    chk("tie_corr", longint'($signed(corr1)), 0);

    // Modulated carrier 1,0,1 with 30% sample gaps on the 4-period instance.
    clear_mon();
    feed(1536, 3, 30, 1'b1, 5);
    step();
    chk("car_n", longint'(s4_corr.size()), 3);
    if (s4_corr.size() == 3) begin
      chk("car_b0", s4_bit[0], 1);
      chk("car_b1", s4_bit[1], 0);
      chk("car_b2", s4_bit[2], 1);
      chk("car_gap1", s4_at[1] - s4_at[0], 512);
      chk("car_gap2", s4_at[2] - s4_at[1], 512);
      chk("car_mag", s4_corr[1], -s4_corr[0]);
      chk("car_alt", s4_corr[2], s4_corr[0]);
    end

    // Re-sync after a partial bit: only the following full bit strobes.
    clear_mon();
    feed(300, 3, 0, 1'b1, 0);
    feed(512, 3, 0, 1'b1, 1);
    step();
    chk("resync_n", longint'(s4_corr.size()), 1);
    if (s4_corr.size() == 1) chk("resync_bit", s4_bit[0], 1);

    // Enable dropped mid-frame.
    clear_mon();
    feed(100, 0, 0, 1'b1, 0);
    saved_cnt = int'(cnt1);
    enable = 1'b0;
    step();
    chk("en_lock1", longint'(lk1), 0);
    chk("en_lock4", longint'(lk4), 0);
    feed(200, 0, 0, 1'b0, 0);
    chk("en_nostrobe4", longint'(s4_corr.size()), 0);
    chk("en_cnt1", longint'(cnt1), saved_cnt);
    enable = 1'b1;
    step();

    // Asynchronous reset 50 samples into a frame.
    feed(50, 0, 0, 1'b1, 0);
    @(negedge clk);
    reset_n = 1'b0;
    #1;
    model_reset();
    chk("arst_cnt1", longint'(cnt1), 0);
    chk("arst_corr1", longint'($signed(corr1)), 0);
    chk("arst_lock1", longint'(lk1), 0);
    chk("arst_bit1", longint'(bo1), 0);
    step();
    step();
    @(negedge clk);
    reset_n = 1'b1;
    feed(128, 0, 0, 1'b1, 0);
    chk("post_rst_bv", longint'(bv1), 1);
    chk("post_rst_corr", longint'($signed(corr1)), 16320);
    chk("post_rst_cnt", longint'(cnt1), 1);

    // Random traffic against the model.
    sync = 1'b1; sample_valid = 1'b1; sample = 8'($urandom_range(255));
    step();
    for (int i = 0; i < 6000; i++) begin
      if (enable) enable = ($urandom_range(2999) != 0);
      else        enable = ($urandom_range(19) == 0);
      sync         = ($urandom_range(2499) == 0) || (enable && !lk1 && $urandom_range(9) == 0);
      sample_valid = ($urandom_range(3) != 0);
      sample       = 8'($urandom_range(255));
      step();
    end
    sync = 1'b0; sample_valid = 1'b0;
    step();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/bpsk_demod.md
Name: bpsk_demod

Overview:
Coherent BPSK demodulator, the receive end of the table-driven BPSK modulator path. It accepts 8-bit unsigned carrier samples, 128 samples per carrier period, with the carrier shaped as 127.5 - 127.5*cos(2*pi*k/128). It correlates each sample against a locally generated square reference aligned to the carrier phase, integrates over one bit period and slices the sign into a recovered bit. It sits between the ADC/loopback sample source and the bit sink or frame logic.

Parameters:
CYCLES_PER_BIT, 4, carrier periods per data bit (1..255).
ACC_W, 24, signed accumulator width; must satisfy 2^(ACC_W-1) > 128*128*CYCLES_PER_BIT.

Ports:
clk  input  1  system clock, rising-edge.
reset_n  input  1  asynchronous active-low reset.
enable  input  1  demodulator enable; low forces IDLE.
sync  input  1  one-cycle pulse marking sample index 0 of a bit frame (phase 0, first carrier period).
sample_valid  input  1  qualifies sample; one sample per high cycle.
sample  input  8  unsigned carrier sample.
bit_out  output  1  recovered bit, valid while bit_valid is high, held until the next decision.
bit_valid  output  1  one-cycle strobe per decided bit.
corr_out  output  ACC_W  signed correlation total of the last decided bit, held.
bit_count  output  16  number of bits decided since reset; wraps 65535->0.
locked  output  1  high in RUN state.

Behaviour:
- Reset (async, reset_n low): state IDLE; phase=0, cyc=0, acc=0; bit_out=0, bit_valid=0, corr_out=0, bit_count=0, locked=0.
- States: IDLE, RUN.
- IDLE -> RUN when enable=1 and sync=1. If sample_valid=1 in the same cycle, that sample is accepted as phase 0.
- RUN -> IDLE when enable=0. The partial accumulation is discarded and no bit_valid is issued.
- Sync in RUN restarts the frame: phase=0, cyc=0, acc=0, and any partial bit is discarded with no strobe. If sample_valid is also high, that sample is processed as phase 0 of the new frame.
- Per accepted sample in RUN:
  - centered = sample - 128, signed 9-bit, range -128..+127.
  - Reference sign is +1 for phase 32..95 and -1 for phase 0..31 and 96..127.
  - acc += sign*centered, sign-extended to ACC_W.
- Phase is a 7-bit counter that increments per accepted sample and wraps 127->0. On each wrap, cyc increments.
- Decision happens on the sample with phase=127 and cyc=CYCLES_PER_BIT-1:
  - The final total is acc including that sample.
  - On the next clock edge: bit_out = (total > 0), with a tie or negative total giving 0; corr_out = total; bit_valid=1 for exactly one cycle; bit_count increments.
  - acc and cyc are cleared at the same edge, and the next sample starts the next bit. Bits are back-to-back with no gap.
  - Latency is one clock from acceptance of the final sample to bit_valid.
- sample_valid low: all counters and acc hold. Gaps of any length are allowed.
- sample_valid is ignored in IDLE. bit_valid is never asserted in IDLE.
- Accumulation is non-saturating; the ACC_W rule above guarantees no overflow.

Test Plan:
- Reset mid-frame (reset_n low during RUN, after 50 samples) -> all outputs return to their reset values immediately; the next sync starts a clean frame.
- CYCLES_PER_BIT=1; sync, then 128 samples with 255 at phase 32..95 and 0 elsewhere -> bit_valid one cycle after the last sample, bit_out=1, corr_out=16320, bit_count=1.
- Same frame with the pattern inverted (0 at phase 32..95, 255 elsewhere) -> bit_out=0, corr_out=-16320.
- Constant 255 for 128 samples -> corr_out=0, bit_out=0 (tie rule).
- CYCLES_PER_BIT=4; modulator carrier for bits 1,0,1 with sample_valid randomly low 30% of the time -> three strobes spaced 512 accepted samples apart, bits 1,0,1, corr_out equal in magnitude with alternating sign.
- Second sync after 300 samples of a frame -> no strobe for the partial bit; the following full bit decodes correctly. enable dropped mid-frame -> locked=0 and no strobe.
